// File: rtl/stream_demux_pkg.sv
// Shared types for the stream demultiplexer.
// Occupancy encoding, beat layout and select sizing.
package stream_demux_pkg;

  typedef enum logic [1:0] {
    OCC_EMPTY,
    OCC_ONE,
    OCC_TWO
  } occ_t;

  localparam int BEAT_DATA_W = 8;
  localparam int BEAT_SEL_W  = 1;

  typedef struct packed {
    logic [BEAT_DATA_W-1:0] data;
    logic [BEAT_SEL_W-1:0]  sel;
  } beat_t;

  function automatic int sel_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stream_demux_skid.sv
// Two-entry skid buffer, valid/ready on both sides.
// Registered in_ready keeps the input free of output paths.
module stream_demux_skid
  import stream_demux_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  occ_t state;
  occ_t state_nxt;

  logic [W-1:0] head;
  logic [W-1:0] skid;
  logic in_fire;
  logic out_fire;
  logic load_h_in;
  logic load_h_k;
  logic load_k;

  assign out_valid = (state != OCC_EMPTY);
  assign out_data  = head;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  // Occupancy next state and register load enables
  always_comb begin
    state_nxt = state;
    load_h_in = 1'b0;
    load_h_k  = 1'b0;
    load_k    = 1'b0;
    unique case (state)
      OCC_EMPTY: begin
        if (in_fire) begin
          state_nxt = OCC_ONE;
          load_h_in = 1'b1;
        end
      end
      OCC_ONE: begin
        if (in_fire && out_fire) begin
          load_h_in = 1'b1;
        end else if (in_fire) begin
          state_nxt = OCC_TWO;
          load_k    = 1'b1;
        end else if (out_fire) begin
          state_nxt = OCC_EMPTY;
        end
      end
      OCC_TWO: begin
        if (out_fire) begin
          state_nxt = OCC_ONE;
          load_h_k  = 1'b1;
        end
      end
      default: state_nxt = OCC_EMPTY;
    endcase
  end

  // Occupancy state and registered ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= OCC_EMPTY;
      in_ready <= 1'b0;
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt != OCC_TWO);
    end
  end

  // Head and skid payload registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      skid <= '0;
    end else begin
      if (load_h_in) head <= in_data;
      else if (load_h_k) head <= skid;
      if (load_k) skid <= in_data;
    end
  end

  a_no_in_when_full: assert property (
    @(posedge clk) disable iff (!rst_n)
    (state == OCC_TWO) |-> !in_fire
  );

endmodule

// File: rtl/stream_demux.sv
// Registered 1-to-NUM_OUT stream demultiplexer.
// Steers beats by select; drops illegal selects.
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int NUM_OUT = 2,
  parameter int DATA_W  = 8,
  parameter int SEL_W   = sel_w(NUM_OUT),
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [DATA_W-1:0]        s_data,
  input  logic [SEL_W-1:0]         s_sel,
  output logic [NUM_OUT-1:0]       m_valid,
  input  logic [NUM_OUT-1:0]       m_ready,
  output logic [DATA_W-1:0]        m_data,
  output logic                     drop_pulse,
  output logic [NUM_OUT*CNT_W-1:0] xfer_cnt,
  output logic [CNT_W-1:0]         drop_cnt
);

  localparam int PW = DATA_W + SEL_W;
  localparam logic [SEL_W:0] LIMIT = (SEL_W + 1)'(NUM_OUT);

  logic             illegal;
  logic             drop_fire;
  logic             head_valid;
  logic             head_ready;
  logic [PW-1:0]    head;
  logic [SEL_W-1:0] head_sel;
  logic [CNT_W-1:0] cnt [NUM_OUT];

  assign illegal   = ({1'b0, s_sel} >= LIMIT);
  assign drop_fire = s_valid && s_ready && illegal;

  stream_demux_skid #(
    .W (PW)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s_valid && !illegal),
    .in_ready  (s_ready),
    .in_data   ({s_data, s_sel}),
    .out_valid (head_valid),
    .out_ready (head_ready),
    .out_data  (head)
  );

  assign m_data     = head[PW-1:SEL_W];
  assign head_sel   = head[SEL_W-1:0];
  assign head_ready = |(m_valid & m_ready);

  // Decode head select into one-hot port valid
  always_comb begin
    m_valid = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      m_valid[i] = head_valid && (head_sel == SEL_W'(i));
    end
  end

  // Per-port completed-transfer counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_OUT; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_OUT; i++) begin
        if (m_valid[i] && m_ready[i]) cnt[i] <= cnt[i] + CNT_W'(1);
      end
    end
  end

  // Pack counters onto the flat output bus
  always_comb begin
    xfer_cnt = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      xfer_cnt[i*CNT_W +: CNT_W] = cnt[i];
    end
  end

  // Drop pulse and drop counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_pulse <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      drop_pulse <= drop_fire;
      if (drop_fire) drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

  a_onehot: assert property (
    @(posedge clk) disable iff (!rst_n)
    $onehot0(m_valid)
  );

  a_hold: assert property (
    @(posedge clk) disable iff (!rst_n)
    (|(m_valid & ~m_ready)) |=> $stable(m_data)
  );

endmodule

// File: tb/tb_stream_demux.sv
// Directed bench for stream_demux.
// NUM_OUT=3, CNT_W=4 to reach drop and wrap cases.
module tb_stream_demux;

  localparam int NO = 3;
  localparam int DW = 8;
  localparam int SW = 2;
  localparam int CW = 4;

  logic          clk;
  logic          rst_n;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic [SW-1:0] s_sel;
  logic [NO-1:0] m_valid;
  logic [NO-1:0] m_ready;
  logic [DW-1:0] m_data;
  logic          drop_pulse;
  logic [NO*CW-1:0] xfer_cnt;
  logic [CW-1:0] drop_cnt;

  int errors = 0;
  int checks = 0;

  stream_demux #(
    .NUM_OUT (NO),
    .DATA_W  (DW),
    .SEL_W   (SW),
    .CNT_W   (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_sel      (s_sel),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .drop_pulse (drop_pulse),
    .xfer_cnt   (xfer_cnt),
    .drop_cnt   (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v,
                       input logic [SW-1:0] sel,
                       input logic [DW-1:0] d);
    s_valid = v;
    s_sel   = sel;
    s_data  = d;
  endtask

  initial begin
    rst_n   = 1'b0;
    m_ready = '0;
    drive(1'b0, 2'd0, 8'h00);
    #1;
    chk("rst_s_ready", 32'(s_ready), 32'h0);
    chk("rst_m_valid", 32'(m_valid), 32'h0);
    chk("rst_m_data", 32'(m_data), 32'h0);
    chk("rst_drop", 32'(drop_pulse), 32'h0);
    repeat (3) tick();
    rst_n = 1'b1;
    chk("pre_edge_ready", 32'(s_ready), 32'h0);
    tick();
    chk("idle_ready", 32'(s_ready), 32'h1);
    chk("idle_m_valid", 32'(m_valid), 32'h0);
    chk("idle_xfer", 32'(xfer_cnt), 32'h0);
    chk("idle_dcnt", 32'(drop_cnt), 32'h0);

    // streaming, sels 0,1,0,1
    m_ready = 3'b111;
    drive(1'b1, 2'd0, 8'hA0);
    tick();
    chk("st0_valid", 32'(m_valid), 32'h1);
    chk("st0_data", 32'(m_data), 32'hA0);
    drive(1'b1, 2'd1, 8'hA1);
    tick();
    chk("st1_valid", 32'(m_valid), 32'h2);
    chk("st1_data", 32'(m_data), 32'hA1);
    chk("st1_ready", 32'(s_ready), 32'h1);
    drive(1'b1, 2'd0, 8'hA2);
    tick();
    chk("st2_valid", 32'(m_valid), 32'h1);
    chk("st2_data", 32'(m_data), 32'hA2);
    drive(1'b1, 2'd1, 8'hA3);
    tick();
    chk("st3_valid", 32'(m_valid), 32'h2);
    chk("st3_data", 32'(m_data), 32'hA3);
    drive(1'b0, 2'd0, 8'h00);
    tick();
    chk("st_drain", 32'(m_valid), 32'h0);
    chk("st_xfer", 32'(xfer_cnt), 32'h022);

    // backpressure on port 1
    m_ready = 3'b101;
    drive(1'b1, 2'd1, 8'h11);
    tick();
    chk("bp_a_valid", 32'(m_valid), 32'h2);
    chk("bp_a_data", 32'(m_data), 32'h11);
    chk("bp_a_ready", 32'(s_ready), 32'h1);
    drive(1'b1, 2'd1, 8'h22);
    tick();
    chk("bp_b_ready", 32'(s_ready), 32'h0);
    chk("bp_b_data", 32'(m_data), 32'h11);
    drive(1'b1, 2'd1, 8'h33);
    tick();
    chk("bp_c_ready", 32'(s_ready), 32'h0);
    chk("bp_c_data", 32'(m_data), 32'h11);
    chk("bp_c_valid", 32'(m_valid), 32'h2);
    m_ready = 3'b111;
    tick();
    chk("bp_d_data", 32'(m_data), 32'h22);
    chk("bp_d_ready", 32'(s_ready), 32'h1);
    tick();
    chk("bp_e_data", 32'(m_data), 32'h33);
    chk("bp_e_valid", 32'(m_valid), 32'h2);
    drive(1'b0, 2'd0, 8'h00);
    tick();
    chk("bp_drain", 32'(m_valid), 32'h0);
    chk("bp_xfer", 32'(xfer_cnt), 32'h052);

    // head-of-line blocking
    m_ready = 3'b010;
    drive(1'b1, 2'd0, 8'h44);
    tick();
    drive(1'b1, 2'd1, 8'h55);
    tick();
    drive(1'b0, 2'd0, 8'h00);
    chk("hol_a_valid", 32'(m_valid), 32'h1);
    chk("hol_a_data", 32'(m_data), 32'h44);
    tick();
    chk("hol_b_valid", 32'(m_valid), 32'h1);
    m_ready = 3'b011;
    tick();
    chk("hol_c_valid", 32'(m_valid), 32'h2);
    chk("hol_c_data", 32'(m_data), 32'h55);
    tick();
    chk("hol_drain", 32'(m_valid), 32'h0);
    chk("hol_xfer", 32'(xfer_cnt), 32'h063);

    // illegal destination
    drive(1'b1, 2'd3, 8'h55);
    chk("ill_ready", 32'(s_ready), 32'h1);
    tick();
    drive(1'b0, 2'd0, 8'h00);
    chk("ill_pulse", 32'(drop_pulse), 32'h1);
    chk("ill_dcnt", 32'(drop_cnt), 32'h1);
    chk("ill_valid", 32'(m_valid), 32'h0);
    tick();
    chk("ill_pulse_end", 32'(drop_pulse), 32'h0);
    chk("ill_valid2", 32'(m_valid), 32'h0);

    // wrap of port 0 counter: 3 + 13 = 16 -> 0
    m_ready = 3'b111;
    for (int i = 0; i < 13; i++) begin
      drive(1'b1, 2'd0, 8'(i));
      tick();
    end
    drive(1'b0, 2'd0, 8'h00);
    chk("wrap_pre", 32'(xfer_cnt), 32'h06F);
    tick();
    chk("wrap_post", 32'(xfer_cnt), 32'h060);

    // reset while full
    m_ready = 3'b000;
    drive(1'b1, 2'd2, 8'h77);
    tick();
    drive(1'b1, 2'd2, 8'h88);
    tick();
    chk("mr_full_ready", 32'(s_ready), 32'h0);
    chk("mr_full_valid", 32'(m_valid), 32'h4);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mr_valid", 32'(m_valid), 32'h0);
    chk("mr_ready", 32'(s_ready), 32'h0);
    chk("mr_xfer", 32'(xfer_cnt), 32'h0);
    chk("mr_dcnt", 32'(drop_cnt), 32'h0);
    chk("mr_pulse", 32'(drop_pulse), 32'h0);
    chk("mr_data", 32'(m_data), 32'h0);
    drive(1'b0, 2'd0, 8'h00);
    tick();
    rst_n = 1'b1;
    tick();
    chk("mr_after_ready", 32'(s_ready), 32'h1);
    chk("mr_after_valid", 32'(m_valid), 32'h0);
    chk("mr_after_pulse", 32'(drop_pulse), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
